fpu_issue_controller: RTL

- Issue/writeback sequencer sitting between the execute-stage decode and Fixed_Point_Unit.
- Accepts one fixed-point request and registers the operands and operation, holding them stable for the FPU's whole multi-cycle computation.
- Qualifies the FPU `ready` signal, buffers the result, and presents it to register writeback with a valid/ack handshake.
- Handles the pipeline stall, flush and hung-unit timeout.

---
 rtl/fpu_issue_controller_pkg.sv | 22 ++
 rtl/fpu_wait_counter.sv | 42 ++++
 rtl/fpu_issue_controller.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_controller_pkg.sv
// Shared definitions for the FPU issue/writeback sequencer: operation codes
// (common with Fixed_Point_Unit) and controller state encodings.
package fpu_issue_controller_pkg;

    typedef logic [1:0] fpu_op_t;
    typedef logic [1:0] fsm_state_t;

    localparam fpu_op_t FPU_ADD  = 2'd0;
    localparam fpu_op_t FPU_SUB  = 2'd1;
    localparam fpu_op_t FPU_MUL  = 2'd2;
    localparam fpu_op_t FPU_SQRT = 2'd3;

    localparam fsm_state_t ST_IDLE  = 2'd0;
    localparam fsm_state_t ST_ISSUE = 2'd1;
    localparam fsm_state_t ST_WAIT  = 2'd2;
    localparam fsm_state_t ST_DONE  = 2'd3;

    function automatic logic is_idle(input fsm_state_t st);
        return st == ST_IDLE;
    endfunction

endpackage

// File: rtl/fpu_wait_counter.sv
// Saturating WAIT-state cycle counter: flags the end of the ready-blanking
// window and the hung-unit timeout.
module fpu_wait_counter #(
    parameter int TIMEOUT      = 63,
    parameter int BLANK_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic blank_done,
    output logic expired
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LIMIT)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign blank_done = (count_q >= BLANK);
    assign expired    = (count_q == LIMIT);

endmodule

// File: rtl/fpu_issue_controller.sv
// Issue/writeback sequencer between execute-stage decode and Fixed_Point_Unit:
// holds operands for the multi-cycle op, qualifies ready, buffers the result.
module fpu_issue_controller
    import fpu_issue_controller_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int RD_BITS      = 5,
    parameter int BLANK_CYCLES = 1,
    parameter int TIMEOUT      = 63
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [WIDTH-1:0]   req_operand_1,
    input  logic [WIDTH-1:0]   req_operand_2,
    input  logic [RD_BITS-1:0] req_rd,
    input  logic               flush,
    output logic [WIDTH-1:0]   fpu_operand_1,
    output logic [WIDTH-1:0]   fpu_operand_2,
    output logic [1:0]         fpu_operation,
    output logic               fpu_start,
    input  logic [WIDTH-1:0]   fpu_result,
    input  logic               fpu_ready,
    output logic               wb_valid,
    input  logic               wb_ack,
    output logic [WIDTH-1:0]   wb_result,
    output logic [RD_BITS-1:0] wb_rd,
    output logic               wb_error,
    output logic               busy
);

    fsm_state_t         state_q, state_d;
    logic               req_ready_q, req_ready_d;
    fpu_op_t            op_q, op_d;
    logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic [RD_BITS-1:0] rd_q, rd_d;
    logic               start_q, start_d;
    logic               wb_valid_q, wb_valid_d;
    logic [WIDTH-1:0]   wb_result_q, wb_result_d;
    logic [RD_BITS-1:0] wb_rd_q, wb_rd_d;
    logic               wb_error_q, wb_error_d;
    logic               busy_q, busy_d;
    logic               cnt_clear, cnt_enable, blank_done, expired;

    fpu_wait_counter #(
        .TIMEOUT      (TIMEOUT),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .clear      (cnt_clear),
        .enable     (cnt_enable),
        .blank_done (blank_done),
        .expired    (expired)
    );

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        op_d        = op_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        rd_d        = rd_q;
        start_d     = 1'b0;
        wb_valid_d  = wb_valid_q;
        wb_result_d = wb_result_q;
        wb_rd_d     = wb_rd_q;
        wb_error_d  = wb_error_q;
        cnt_clear   = 1'b0;
        cnt_enable  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                op_d        = FPU_ADD;
                if (req_valid && req_ready_q && !flush) begin
                    op_d        = req_op;
                    opa_d       = req_operand_1;
                    opb_d       = req_operand_2;
                    rd_d        = req_rd;
                    req_ready_d = 1'b0;
                    start_d     = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_clear = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_enable = 1'b1;
                // A qualified ready beats a simultaneous timeout.
                if (fpu_ready && blank_done) begin
                    wb_result_d = fpu_result;
                    wb_error_d  = 1'b0;
                    wb_rd_d     = rd_q;
                    wb_valid_d  = 1'b1;
                    state_d     = ST_DONE;
                end else if (expired) begin
                    wb_result_d = '0;
                    wb_error_d  = 1'b1;
                    wb_rd_d     = rd_q;
                    wb_valid_d  = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            default: begin
                if (wb_ack) begin
                    wb_valid_d  = 1'b0;
                    req_ready_d = 1'b1;
                    op_d        = FPU_ADD;
                    state_d     = ST_IDLE;
                end
            end
        endcase
        if (flush) begin
            state_d     = ST_IDLE;
            wb_valid_d  = 1'b0;
            wb_error_d  = 1'b0;
            start_d     = 1'b0;
            req_ready_d = 1'b1;
            op_d        = FPU_ADD;
        end
        busy_d = !is_idle(state_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            op_q        <= FPU_ADD;
            opa_q       <= '0;
            opb_q       <= '0;
            rd_q        <= '0;
            start_q     <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_result_q <= '0;
            wb_rd_q     <= '0;
            wb_error_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            op_q        <= op_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            rd_q        <= rd_d;
            start_q     <= start_d;
            wb_valid_q  <= wb_valid_d;
            wb_result_q <= wb_result_d;
            wb_rd_q     <= wb_rd_d;
            wb_error_q  <= wb_error_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign fpu_operation = op_q;
    assign fpu_operand_1 = opa_q;
    assign fpu_operand_2 = opb_q;
    assign fpu_start     = start_q;
    assign wb_valid      = wb_valid_q;
    assign wb_result     = wb_result_q;
    assign wb_rd         = wb_rd_q;
    assign wb_error      = wb_error_q;
    assign busy          = busy_q;

endmodule
